// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core (master) and the data memory responder (slave).
// The core drives the request fields; the responder drives the handshake and response fields.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        addr_error;
  logic        busy;

  modport master (
    output req_valid, mem_write, data_addr, write_data,
    input  req_ready, resp_valid, read_data, addr_error, busy
  );

  modport slave (
    input  req_valid, mem_write, data_addr, write_data,
    output req_ready, resp_valid, read_data, addr_error, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM answering one request at a time after WAIT_CYCLES wait states.
// resp_valid pulses WAIT_CYCLES+1 cycles after acceptance; req_ready stays low until back in IDLE.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int         WORDS     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              cnt_q;
  logic [3:0]              cnt_d;
  req_t                    req_q;
  req_t                    live_req;
  req_t                    cur_req;
  logic                    accept;
  logic                    commit;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    err;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    ram_we;
  logic [31:0]             read_data_q;
  logic                    err_q;
  logic [31:0]             mem [WORDS];

  assign live_req = '{we: bus.mem_write, addr: bus.data_addr, wdata: bus.write_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With no wait states the commit edge is the acceptance edge, so decode straight off the bus.
  assign cur_req = (state_q == IDLE) ? live_req : req_q;
  assign commit  = (state_d == RESP) && (state_q != RESP);

  assign misaligned   = (cur_req.addr[1:0] != 2'b00);
  assign out_of_range = |cur_req.addr[31:ADDR_WIDTH+2];
  assign err          = misaligned | out_of_range;
  assign idx          = cur_req.addr[ADDR_WIDTH+1:2];

  // A commit computed while reset is held must not reach the unreset RAM.
  assign ram_we = commit & ~err & cur_req.we & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      read_data_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= live_req;
      end
      if (commit) begin
        err_q <= err;
        if (err) begin
          read_data_q <= 32'd0;
        end else if (cur_req.we) begin
          read_data_q <= cur_req.wdata;
        end else begin
          read_data_q <= mem[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx] <= cur_req.wdata;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.addr_error = (state_q == RESP) & err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.read_data  = read_data_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data port: accepts the core's store/load requests (mem_write, data_addr, write_data) and answers with read data after a configurable number of wait states.
- Lets the multicycle/pipelined core run against realistic non-zero memory latency. It also flags bad addresses instead of silently aliasing them.
- Sits between the core's data interface and the word-addressed data RAM. It contains the RAM array itself.

Parameters:
- ADDR_WIDTH, 6, number of word-index bits. The RAM holds 2**ADDR_WIDTH 32-bit words, so the default is 64 words = 256 bytes.
- WAIT_CYCLES, 2, number of wait states between request acceptance and response. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  input  1  initiator has a request on data_addr/write_data/mem_write
- req_ready  output  1  responder can accept a request this cycle
- mem_write  input  1  1 = store, 0 = load; sampled at acceptance
- data_addr  input  32  byte address; sampled at acceptance
- write_data  input  32  store data; sampled at acceptance
- resp_valid  output  1  one-cycle pulse: response and read_data valid
- read_data  output  32  load result (store: echo of stored word)
- addr_error  output  1  qualifies resp_valid: request was misaligned or out of range
- busy  output  1  high while a request is outstanding (state != IDLE)

Behaviour:
- Reset (reset=0, asynchronous) forces the following; the RAM array is not reset:
  - state=IDLE
  - req_ready=1, resp_valid=0, addr_error=0, busy=0
  - read_data=0, wait counter=0
- FSM states IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Acceptance = req_valid & req_ready at a rising edge. On acceptance, latch addr, data and we into request registers.
    - If WAIT_CYCLES>0: load counter=WAIT_CYCLES, go to WAIT.
    - If WAIT_CYCLES=0: go directly to RESP.
  - WAIT: req_ready=0, counter decrements each cycle. When counter==1, next state is RESP.
  - RESP: resp_valid=1 and addr_error valid for exactly one cycle; req_ready=0. Next state is always IDLE.
- Latency: resp_valid is high in cycle N+WAIT_CYCLES+1, where N is the acceptance edge. Minimum request spacing is WAIT_CYCLES+2 cycles.
- No back-to-back acceptance in RESP: req_valid is ignored whenever req_ready=0, and the initiator must hold the request until accepted.
- Address decode:
  - Word index = addr[ADDR_WIDTH+1:2].
  - Misaligned if addr[1:0]!=0.
  - Out of range if addr[31:ADDR_WIDTH+2]!=0.
  - Either condition: error.
- Commit timing: RAM write and read_data update occur on the edge that enters RESP.
  - Valid store: RAM[index] <= wdata; read_data <= wdata.
  - Valid load: read_data <= RAM[index]. The value is the one present before any same-edge write, which cannot happen because there is one outstanding request.
  - Error (load or store): no RAM write; read_data <= 0; addr_error=1 during RESP.
- read_data holds its value after RESP until the next response. addr_error is 0 outside RESP.
- Changes on data_addr/write_data/mem_write after acceptance have no effect.
- Reset asserted mid-WAIT: the request is aborted with no RAM write. The FSM returns to IDLE asynchronously, and RAM contents written earlier are preserved.
- Reset asserted during RESP: resp_valid drops immediately. The write already committed stays committed.
- Counter is 4 bits, and WAIT_CYCLES=0 never loads it, so there is no wrap-around.

Test Plan:
- Store then load (defaults): accept store addr=84, data=7 at edge N.
  - Required: resp_valid=1 only in cycle N+3, addr_error=0, read_data=7.
  - Then load addr=84: resp_valid at acceptance+3 with read_data=7. Load addr=80 (never written after a write of 0x0000_0005 to 80) returns 5.
- Handshake hold-off: keep req_valid=1 continuously with alternating requests.
  - Required: req_ready=0 and busy=1 in WAIT/RESP. Accepts exactly every 4 cycles, and no request is dropped or duplicated (count resp_valid pulses = requests issued).
- Bad addresses:
  - Store to 0x52 (misaligned) -> resp_valid with addr_error=1, read_data=0.
  - Store to 0x100 (out of range for ADDR_WIDTH=6) -> addr_error=1.
  - Subsequent loads from 0x50 and 0x00 return their prior contents unchanged.
- Reset mid-operation: write 0x1234 to addr 8, then accept a store of 0xFFFF to addr 8. Pull reset low one cycle into WAIT.
  - Required: outputs at reset values immediately, no resp_valid.
  - After release, a load from 8 returns 0x1234.
- Zero wait states (WAIT_CYCLES=0): store addr=4 data=0xA5A5A5A5.
  - Required: resp_valid in cycle N+1, next acceptance possible at N+2, and a load from 4 returns 0xA5A5A5A5.
- Max wait states (WAIT_CYCLES=15): one load.
  - Required: resp_valid exactly at N+16, busy high for 16 cycles, no early or duplicate pulse.
